obi_apb_bridge: RTL and testbench
=================================

Name: obi_apb_bridge

Overview:
Converts one OBI slave port of the system-bus interconnect into an APB4 master port for slow peripherals such as UART, GPIO and timers. It sits directly downstream of an interconnect slave port and accepts one OBI transaction at a time. Each accepted transaction is run as a SETUP/ACCESS APB transfer, and exactly one OBI response is returned per grant, for reads and writes alike. APB slave errors are reported on a sideband error flag that accompanies the response.

Parameters:
APB_ADDR_WIDTH, 16, width of paddr_o; taken from addr_i[APB_ADDR_WIDTH-1:0] (legal range 2..32)
TIMEOUT_CYCLES, 255, ACCESS-phase cycles before abort; used only when OBI_APB_TIMEOUT_EN is defined (legal range 1..65535)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
req_i  in  1  OBI request
gnt_o  out  1  OBI grant
rvalid_o  out  1  OBI response valid, single-cycle pulse
we_i  in  1  OBI write enable
be_i  in  4  OBI byte enables
addr_i  in  32  OBI byte address
wdata_i  in  32  OBI write data
rdata_o  out  32  OBI read data, valid with rvalid_o
err_o  out  1  error flag, valid only with rvalid_o
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write
paddr_o  out  APB_ADDR_WIDTH  APB address
pwdata_o  out  32  APB write data
pstrb_o  out  4  APB write strobes
pprot_o  out  3  APB protection, constant 3'b000
pready_i  in  1  APB ready
prdata_i  in  32  APB read data
pslverr_i  in  1  APB slave error

Behaviour:
- Reset: state IDLE.
  - All registered outputs reset to 0: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, rvalid_o, rdata_o, err_o.
  - Assertion of rst_ni mid-transfer drops psel_o/penable_o immediately (asynchronously). No response is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- Grant: gnt_o = req_i & (state==IDLE | state==RESP), combinational.
  - On gnt_o, register addr_i[APB_ADDR_WIDTH-1:0], we_i, wdata_i, and pstrb = we_i ? be_i : 4'b0.
  - Next state on gnt_o is SETUP.
- IDLE: no request -> stay IDLE.
- SETUP: psel_o=1, penable_o=0 -> ACCESS unconditionally.
- ACCESS: psel_o=1, penable_o=1.
  - pready_i=0 -> stay in ACCESS; all APB outputs held stable.
  - pready_i=1 -> capture rdata = pwrite ? 32'h0 : prdata_i and capture err = pslverr_i; go to RESP.
- RESP: rvalid_o=1, rdata_o/err_o from the captured values. psel_o=0, penable_o=0.
  - req_i -> grant (see above), next state SETUP.
  - No request -> IDLE.
- rvalid_o is registered and lasts exactly one cycle per grant.
- Zero-wait-state latency: gnt at T0, SETUP T1, ACCESS T2, rvalid T3.
- Back-to-back throughput: one transfer per 3 cycles.
- Stability: rdata_o and err_o hold their last values outside rvalid_o; consumers must qualify them with rvalid_o.
- No buffering: at most one outstanding transaction. req_i while in SETUP or ACCESS gets gnt_o=0.
- Addresses above APB_ADDR_WIDTH are truncated. No bridge-side decoding is done; the interconnect decodes upstream.
- pprot_o is tied to 3'b000.

Optional Feature:
OBI_APB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TIMEOUT_CYCLES with pready_i still 0, the transfer aborts: go to RESP with rdata=32'h0 and err=1.
  - psel_o/penable_o drop on the cycle RESP is entered.
  - pready_i=1 on the same cycle the count reaches TIMEOUT_CYCLES counts as normal completion (ready wins).
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter logic; ACCESS waits indefinitely for pready_i; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package obi_apb_pkg: typedef enum logic [1:0] state (IDLE, SETUP, ACCESS, RESP), constant APB_PROT_DEFAULT = 3'b000, constant TIMEOUT_RDATA = 32'h0.
- One natural sub-module, obi_apb_timeout_cnt (clear/enable/expired), instantiated only under OBI_APB_TIMEOUT_EN. All other logic stays inline.

Test Plan:
- Zero-wait read: req=1, we=0, addr=32'h4000_0010, pready=1, prdata=32'hA5A5_1234 -> gnt at T0; paddr=16'h0010 with psel only at T1, penable at T2; rvalid=1, rdata=32'hA5A5_1234, err=0 at T3.
- Write with 3 wait states: we=1, be=4'b0011, wdata=32'hCAFE_F00D, pready low 3 cycles -> pstrb=4'b0011, pwdata held stable through all ACCESS cycles; rvalid 6 cycles after gnt, rdata=0.
- Back-to-back: req held high with 2 different addresses -> second gnt coincides with first rvalid; second SETUP on the next cycle; exactly 2 rvalid pulses; gnt=0 during SETUP/ACCESS.
- Slave error: pslverr=1 with pready=1 on a read -> rvalid=1, err=1; next transaction with pslverr=0 gives err=0.
- Reset mid-ACCESS: assert rst_ni low while penable=1 -> psel/penable=0 asynchronously; no rvalid after reset release; a new request completes normally.
- OBI_APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck at 0 -> rvalid with err=1, rdata=0 after 4 ACCESS cycles. Repeat with pready rising on the 4th cycle -> normal completion, err=0.

Source files
------------

// File: rtl/obi_apb_bridge_pkg.sv
// Shared types and constants for the OBI-to-APB4 bridge.
package obi_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [2:0]  APB_PROT_DEFAULT = 3'b000;
    localparam logic [31:0] TIMEOUT_RDATA    = 32'h0;

endpackage

// File: rtl/obi_apb_bridge_if.sv
// OBI slave + APB4 master signal bundle around the bridge.
// slave modport: the bridge's own view (OBI slave, APB master side).
// master modport: the environment (interconnect + APB peripheral).
interface obi_apb_bridge_if #(
    parameter int APB_ADDR_WIDTH = 16
);
    logic                      req_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic                      we_i;
    logic [3:0]                be_i;
    logic [31:0]               addr_i;
    logic [31:0]               wdata_i;
    logic [31:0]               rdata_o;
    logic                      err_o;
    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [31:0]               pwdata_o;
    logic [3:0]                pstrb_o;
    logic [2:0]                pprot_o;
    logic                      pready_i;
    logic [31:0]               prdata_i;
    logic                      pslverr_i;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, pready_i, prdata_i, pslverr_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
               psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, pready_i, prdata_i, pslverr_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
               psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o
    );
endinterface

// File: rtl/obi_apb_bridge_timeout_cnt.sv
// ACCESS-phase watchdog for the OBI-to-APB bridge (built only with OBI_APB_TIMEOUT_EN).
// o_expired flags the wait cycle on which the count reaches TIMEOUT_CYCLES.
module obi_apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int             W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] r_cnt;

    // Count ACCESS cycles spent waiting on pready; restart at every ACCESS entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_cnt <= '0;
        else if (i_clear)  r_cnt <= '0;
        else if (i_enable) r_cnt <= r_cnt + 1'b1;
    end

    // This wait cycle is the one that brings the count to TIMEOUT_CYCLES.
    assign o_expired = i_enable & (r_cnt == LAST);
endmodule

// File: rtl/obi_apb_bridge.sv
// OBI slave port to APB4 master bridge, one transaction outstanding.
// Optional ACCESS timeout enabled by defining OBI_APB_TIMEOUT_EN.
module obi_apb_bridge
    import obi_apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    obi_apb_bridge_if.slave   bus
);
    state_e                    r_state;
    logic                      r_psel, r_penable, r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [31:0]               r_pwdata;
    logic [3:0]                r_pstrb;
    logic                      r_rvalid, r_err;
    logic [31:0]               r_rdata;
    logic                      w_gnt;
    logic                      w_expired;

    // Accept a new request only when no transfer is in flight.
    assign w_gnt = bus.req_i & ((r_state == IDLE) | (r_state == RESP));

`ifdef OBI_APB_TIMEOUT_EN
    obi_apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_clear  (r_state == SETUP),
        .i_enable ((r_state == ACCESS) & ~bus.pready_i),
        .o_expired(w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // Upper OBI address bits are dropped on purpose; decoding happens upstream.
    generate
        if (APB_ADDR_WIDTH < 32) begin : g_trunc
            logic w_unused_addr;
            assign w_unused_addr = ^bus.addr_i[31:APB_ADDR_WIDTH];
        end
    endgenerate

    // Bridge FSM with all APB/OBI outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_gnt) begin
                        r_paddr  <= bus.addr_i[APB_ADDR_WIDTH-1:0];
                        r_pwrite <= bus.we_i;
                        r_pwdata <= bus.wdata_i;
                        r_pstrb  <= bus.we_i ? bus.be_i : 4'b0;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // Ready beats the watchdog when both land on the same cycle.
                    if (bus.pready_i) begin
                        r_rdata   <= r_pwrite ? 32'h0 : bus.prdata_i;
                        r_err     <= bus.pslverr_i;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_state   <= RESP;
                    end else if (w_expired) begin
                        r_rdata   <= TIMEOUT_RDATA;
                        r_err     <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o     = w_gnt;
    assign bus.rvalid_o  = r_rvalid;
    assign bus.rdata_o   = r_rdata;
    assign bus.err_o     = r_err;
    assign bus.psel_o    = r_psel;
    assign bus.penable_o = r_penable;
    assign bus.pwrite_o  = r_pwrite;
    assign bus.paddr_o   = r_paddr;
    assign bus.pwdata_o  = r_pwdata;
    assign bus.pstrb_o   = r_pstrb;
    assign bus.pprot_o   = APB_PROT_DEFAULT;
endmodule

// File: tb/tb_obi_apb_bridge.sv
// Scoreboard bench for obi_apb_bridge; timeout cases run when OBI_APB_TIMEOUT_EN is defined.
module tb_obi_apb_bridge;
    localparam int AW     = 16;
    localparam int TO_CYC = 4;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tot = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   g_cyc = 0;
    logic [31:0] hold_rd = '0;
    logic        hold_err = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    obi_apb_bridge_if #(.APB_ADDR_WIDTH(AW)) bif ();

    obi_apb_bridge #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every rvalid pulse.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            chk("rst_psel", {31'b0, bif.psel_o}, 32'h0);
            chk("rst_penable", {31'b0, bif.penable_o}, 32'h0);
            chk("rst_rvalid", {31'b0, bif.rvalid_o}, 32'h0);
            chk("rst_rdata", bif.rdata_o, 32'h0);
            hold_rd  = '0;
            hold_err = 1'b0;
        end else begin
            if (bif.rvalid_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_rvalid", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", bif.rdata_o, e.rd);
                    chk("err", {31'b0, bif.err_o}, {31'b0, e.err});
                    chk("latency", cyc - g_cyc, e.lat);
                    chk("resp_psel", {31'b0, bif.psel_o | bif.penable_o}, 32'h0);
                    hold_rd  = e.rd;
                    hold_err = e.err;
                end
            end else begin
                chk("hold_rdata", bif.rdata_o, hold_rd);
                chk("hold_err", {31'b0, bif.err_o}, {31'b0, hold_err});
            end
            if (bif.psel_o && bif.req_i) chk("gnt_busy", {31'b0, bif.gnt_o}, 32'h0);
            if (bif.req_i && bif.gnt_o) g_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One OBI transaction plus the APB slave side; enters and leaves at posedge+1.
    task automatic txn(input logic w, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input int waits, input logic [31:0] prd,
                       input logic slv, input bit to, input bit hold, input bit rv_at_gnt);
        exp_t e;
        int   n_acc;
        int   k;
        logic [3:0] strb;
        n_acc  = to ? TO_CYC : waits + 1;
        strb   = w ? be : 4'b0;
        e.rd   = (w || to) ? 32'h0 : prd;
        e.err  = to ? 1'b1 : slv;
        e.lat  = 2 + n_acc;
        sb.push_back(e);
        bif.req_i     = 1'b1;
        bif.we_i      = w;
        bif.be_i      = be;
        bif.addr_i    = a;
        bif.wdata_i   = wd;
        bif.pready_i  = 1'b0;
        bif.prdata_i  = ~prd;
        bif.pslverr_i = ~slv;
        k = 0;
        @(negedge clk);
        while (!bif.gnt_o && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("gnt", {31'b0, bif.gnt_o}, 32'h1);
        if (rv_at_gnt) chk("gnt_with_rvalid", {31'b0, bif.rvalid_o}, 32'h1);
        @(posedge clk); #1;
        if (!hold) bif.req_i = 1'b0;
        bif.wdata_i = ~wd;
        bif.be_i    = ~be;
        @(negedge clk);
        chk("setup_psel", {31'b0, bif.psel_o}, 32'h1);
        chk("setup_penable", {31'b0, bif.penable_o}, 32'h0);
        chk("setup_paddr", {16'b0, bif.paddr_o}, {16'b0, a[AW-1:0]});
        chk("pprot", {29'b0, bif.pprot_o}, 32'h0);
        @(posedge clk); #1;
        for (int c = 0; c < n_acc; c++) begin
            bif.pready_i = (!to && c == waits);
            if (bif.pready_i) begin
                bif.prdata_i  = prd;
                bif.pslverr_i = slv;
            end
            @(negedge clk);
            chk("acc_psel", {31'b0, bif.psel_o}, 32'h1);
            chk("acc_penable", {31'b0, bif.penable_o}, 32'h1);
            chk("acc_paddr", {16'b0, bif.paddr_o}, {16'b0, a[AW-1:0]});
            chk("acc_pwrite", {31'b0, bif.pwrite_o}, {31'b0, w});
            chk("acc_pwdata", bif.pwdata_o, wd);
            chk("acc_pstrb", {28'b0, bif.pstrb_o}, {28'b0, strb});
            @(posedge clk); #1;
        end
        bif.pready_i  = 1'b0;
        bif.prdata_i  = ~prd;
        bif.pslverr_i = 1'b0;
    endtask

    initial begin
        bif.req_i = 1'b0; bif.we_i = 1'b0; bif.be_i = '0; bif.addr_i = '0;
        bif.wdata_i = '0; bif.pready_i = 1'b0; bif.prdata_i = '0; bif.pslverr_i = 1'b0;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        idle(2);

        // zero-wait read, address truncation
        txn(1'b0, 4'hF, 32'h4000_0010, 32'h0, 0, 32'hA5A5_1234, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // write, 3 wait states
        txn(1'b1, 4'b0011, 32'h4000_0020, 32'hCAFE_F00D, 3, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // back-to-back, req held
        txn(1'b0, 4'hF, 32'h0001_0100, 32'h0, 0, 32'h0000_0011, 1'b0, 1'b0, 1'b1, 1'b0);
        txn(1'b0, 4'hF, 32'h0002_0204, 32'h0, 0, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // slave error then clean read
        txn(1'b0, 4'hF, 32'h0000_0300, 32'h0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        txn(1'b0, 4'hF, 32'h0000_0304, 32'h0, 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        txn(1'b1, 4'b1000, 32'h0000_0308, 32'h0BAD_F00D, 2, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        // random mix
        for (int i = 0; i < 6; i++) begin
            txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
                int'($urandom_range(0, 2)), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            idle(1);
        end

        // reset in the middle of ACCESS: no response may follow
        bif.req_i = 1'b1; bif.we_i = 1'b0; bif.addr_i = 32'h0000_0400; bif.pready_i = 1'b0;
        @(negedge clk);
        chk("rst_test_gnt", {31'b0, bif.gnt_o}, 32'h1);
        @(posedge clk); #1 bif.req_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_test_penable", {31'b0, bif.penable_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_psel", {31'b0, bif.psel_o}, 32'h0);
        chk("async_penable", {31'b0, bif.penable_o}, 32'h0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        idle(4);
        txn(1'b0, 4'hF, 32'h0000_0408, 32'h0, 0, 32'h600D_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

`ifdef OBI_APB_TIMEOUT_EN
        // pready stuck low: abort after TO_CYC ACCESS cycles
        txn(1'b0, 4'hF, 32'h0000_0500, 32'h0, 0, 32'h7777_7777, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        // pready on the last allowed cycle: ready wins
        txn(1'b0, 4'hF, 32'h0000_0504, 32'h0, TO_CYC - 1, 32'h8888_8888, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
`endif

        idle(3);
        chk("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
